// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM ramp controller: generator register select
// encoding, controller FSM states, data width and compare-ceiling helper.
package pwm_pkg;

  localparam int unsigned PWM_W = 16;

  typedef enum logic [1:0] {
    SEL_NOP = 2'd0,
    SEL_CMP = 2'd1,
    SEL_TOP = 2'd2,
    SEL_CNT = 2'd3
  } sel_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LD_TOP = 3'd1,
    ST_LD_CMP = 3'd2,
    ST_LD_CNT = 3'd3,
    ST_RUN_UP = 3'd4,
    ST_RUN_DN = 3'd5,
    ST_ABORT  = 3'd6
  } state_e;

  // Highest compare value of a ramp: top+1, held at all-ones when top is all-ones.
  function automatic logic [PWM_W:0] f_cmp_max(input logic [PWM_W-1:0] top);
    if (top == '1) begin
      return {1'b0, top};
    end
    return {1'b0, top} + {{PWM_W{1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/pwm_period_tick.sv
// Period-end detector and hold counter. Emits a one-cycle step pulse on the
// hold-th period end (hold of 0 behaves as 1) while enabled.
module pwm_period_tick
  import pwm_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [PWM_W-1:0] i_cnt,
  input  logic [PWM_W-1:0] i_top,
  input  logic [7:0]       i_hold,
  output logic             o_step
);

  logic [7:0] r_cnt;
  logic [7:0] w_hold_eff;
  logic       w_pe;

  // Period end detection and step pulse generation.
  always_comb begin
    w_hold_eff = (i_hold == 8'd0) ? 8'd1 : i_hold;
    w_pe       = i_en && (i_cnt == i_top);
    o_step     = w_pe && (r_cnt == (w_hold_eff - 8'd1));
  end

  // Count period ends; cleared outside the run states and on every compare write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || i_clr) begin
      r_cnt <= '0;
    end else if (w_pe) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// PWM duty ramp controller: programs a PWM generator (TOP, CMP, CNT) and then
// ramps the compare value up to top+1 and back down to 0 in hold-period steps.
// Optional macro PWM_RAMP_LOOP_EN: repeat the up/down ramp until stop.
module pwm_ramp_ctrl
  import pwm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [PWM_W-1:0] top_cfg,
  input  logic [PWM_W-1:0] step,
  input  logic [7:0]       hold,
  input  logic [PWM_W-1:0] pwm_cnt,
  output logic [PWM_W-1:0] d,
  output logic [1:0]       sel,
  output logic             busy,
  output logic             done,
  output logic [PWM_W-1:0] cur_cmp
);

  state_e           r_state;
  state_e           w_next;
  logic [PWM_W-1:0] r_top;
  logic [PWM_W-1:0] r_step;
  logic [7:0]       r_hold;
  logic [PWM_W-1:0] r_cmp;
  logic             r_done;

  sel_e             w_sel;
  logic [PWM_W-1:0] w_d;
  logic             w_done_set;
  logic             w_run;
  logic             w_tick;
  logic [PWM_W:0]   w_max;
  logic [PWM_W:0]   w_sum;
  logic [PWM_W-1:0] w_up;
  logic [PWM_W-1:0] w_dn;

  // Next compare candidates for both ramp directions, 17-bit to avoid wrap.
  always_comb begin
    w_max = f_cmp_max(r_top);
    w_sum = {1'b0, r_cmp} + {1'b0, r_step};
    w_up  = (w_sum >= w_max) ? w_max[PWM_W-1:0] : w_sum[PWM_W-1:0];
    w_dn  = (r_cmp > r_step) ? (r_cmp - r_step) : '0;
    w_run = (r_state == ST_RUN_UP) || (r_state == ST_RUN_DN);
  end

  pwm_period_tick u_tick (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (w_run),
    .i_clr   (w_sel == SEL_CMP),
    .i_cnt   (pwm_cnt),
    .i_top   (r_top),
    .i_hold  (r_hold),
    .o_step  (w_tick)
  );

  // State register, latched configuration, last compare value and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_top   <= '0;
      r_step  <= '0;
      r_hold  <= '0;
      r_cmp   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done_set;
      if ((r_state == ST_IDLE) && start) begin
        r_top  <= top_cfg;
        r_step <= (step == '0) ? {{(PWM_W-1){1'b0}}, 1'b1} : step;
        r_hold <= hold;
      end
      if (w_sel == SEL_CMP) begin
        r_cmp <= w_d;
      end
    end
  end

  // Next-state and generator write decode; stop overrides a same-cycle step.
  always_comb begin
    w_next     = r_state;
    w_sel      = SEL_NOP;
    w_d        = '0;
    w_done_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_LD_TOP;
      end
      ST_LD_TOP: begin
        w_sel  = SEL_TOP;
        w_d    = r_top;
        w_next = stop ? ST_ABORT : ST_LD_CMP;
      end
      ST_LD_CMP: begin
        w_sel  = SEL_CMP;
        w_next = stop ? ST_ABORT : ST_LD_CNT;
      end
      ST_LD_CNT: begin
        w_sel  = SEL_CNT;
        w_next = stop ? ST_ABORT : ST_RUN_UP;
      end
      ST_RUN_UP: begin
        if (stop) begin
          w_next = ST_ABORT;
        end else if (w_tick) begin
          w_sel = SEL_CMP;
          w_d   = w_up;
          if (w_up == w_max[PWM_W-1:0]) w_next = ST_RUN_DN;
        end
      end
      ST_RUN_DN: begin
        if (stop) begin
          w_next = ST_ABORT;
        end else if (w_tick) begin
          w_sel = SEL_CMP;
          w_d   = w_dn;
          if (w_dn == '0) begin
            w_done_set = 1'b1;
`ifdef PWM_RAMP_LOOP_EN
            w_next     = ST_RUN_UP;
`else
            w_next     = ST_IDLE;
`endif
          end
        end
      end
      ST_ABORT: begin
        w_sel  = SEL_CMP;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Outputs; cur_cmp shows the value being written in the write cycle itself.
  always_comb begin
    sel     = w_sel;
    d       = w_d;
    busy    = (r_state != ST_IDLE);
    done    = r_done;
    cur_cmp = (w_sel == SEL_CMP) ? w_d : r_cmp;
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: expected compare sequences are built
// from the ramp rules with plain arithmetic; period ends are driven randomly.
module tb_pwm_ramp_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [15:0] top_cfg;
  logic [15:0] step;
  logic [7:0]  hold;
  logic [15:0] pwm_cnt;
  logic [15:0] d;
  logic [1:0]  sel;
  logic        busy;
  logic        done;
  logic [15:0] cur_cmp;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pwm_ramp_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .top_cfg (top_cfg),
    .step    (step),
    .hold    (hold),
    .pwm_cnt (pwm_cnt),
    .d       (d),
    .sel     (sel),
    .busy    (busy),
    .done    (done),
    .cur_cmp (cur_cmp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [1:0] esel, input logic [15:0] ed,
                          input logic ebusy, input logic edone, input logic [15:0] ecur);
    chk({tag, ".sel"},  {30'd0, sel},  {30'd0, esel});
    chk({tag, ".d"},    {16'd0, d},    {16'd0, ed});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, ebusy});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, edone});
    chk({tag, ".cur"},  {16'd0, cur_cmp}, {16'd0, ecur});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] not_top(input logic [15:0] t);
    logic [15:0] v;
    v = 16'($urandom);
    if (v == t) v = v + 16'd1;
    return v;
  endfunction

  // mode 0: full ramp; 1: stop on write index k (k<0 -> random); 2: reset after write k
  task automatic run_ramp(input logic [15:0] t, input logic [15:0] s, input logic [7:0] h,
                          input int mode, input int k);
    int q[$];
    int mx, st, c, hold_eff, pe_cnt, idx, last, budget, kk;
    logic pe;
    mx = (t == 16'hFFFF) ? 65535 : int'(t) + 1;
    st = (s == 16'd0) ? 1 : int'(s);
    hold_eff = (h == 8'd0) ? 1 : int'(h);
    c = 0;
    do begin
      c = (c + st > mx) ? mx : c + st;
      q.push_back(c);
    end while (c != mx);
    do begin
      c = (c > st) ? c - st : 0;
      q.push_back(c);
    end while (c != 0);
    kk = (k < 0) ? $urandom_range(0, q.size() - 1) : k;
    pe_cnt = 0; idx = 0; last = 0; budget = 0;

    tick();
    top_cfg = t; step = s; hold = h; start = 1'b1; stop = 1'b0; pwm_cnt = t;
    #1 chk_outs("idle_start", 2'd0, 16'd0, 1'b0, 1'b0, 16'd0);
    tick();
    start = 1'b0; top_cfg = 16'($urandom); step = 16'($urandom); hold = 8'($urandom);
    #1 chk_outs("ld_top", 2'd2, t, 1'b1, 1'b0, 16'd0);
    tick();
    #1 chk_outs("ld_cmp", 2'd1, 16'd0, 1'b1, 1'b0, 16'd0);
    tick();
    #1 chk_outs("ld_cnt", 2'd3, 16'd0, 1'b1, 1'b0, 16'd0);

    while (budget < 5000) begin
      budget++;
      tick();
      start = ($urandom_range(0, 7) == 0);
      stop = 1'b0;
      pe = ($urandom_range(0, 2) == 0);
      pwm_cnt = pe ? t : not_top(t);
      if (pe) pe_cnt++;
      if (pe && pe_cnt == hold_eff) begin
        pe_cnt = 0;
        if (mode == 1 && idx == kk) begin
          stop = 1'b1;
          #1 chk_outs("stop_pe", 2'd0, 16'd0, 1'b1, 1'b0, 16'(last));
          tick();
          stop = 1'b0; start = 1'b0;
          #1 chk_outs("abort", 2'd1, 16'd0, 1'b1, 1'b0, 16'd0);
          tick();
          #1 chk_outs("abort_idle", 2'd0, 16'd0, 1'b0, 1'b0, 16'd0);
          return;
        end
        #1 chk_outs("cmp_wr", 2'd1, 16'(q[idx]), 1'b1, 1'b0, 16'(q[idx]));
        last = q[idx];
        idx++;
        if (idx == q.size()) begin
          tick();
          start = 1'b0; pwm_cnt = not_top(t);
`ifdef PWM_RAMP_LOOP_EN
          stop = 1'b1;
          #1 chk_outs("loop_done", 2'd0, 16'd0, 1'b1, 1'b1, 16'd0);
          tick();
          stop = 1'b0;
          #1 chk_outs("loop_abort", 2'd1, 16'd0, 1'b1, 1'b0, 16'd0);
          tick();
          #1 chk_outs("loop_idle", 2'd0, 16'd0, 1'b0, 1'b0, 16'd0);
`else
          #1 chk_outs("done", 2'd0, 16'd0, 1'b0, 1'b1, 16'd0);
          tick();
          #1 chk_outs("post_done", 2'd0, 16'd0, 1'b0, 1'b0, 16'd0);
`endif
          return;
        end
        if (mode == 2 && idx == kk) begin
          #2 rst_n = 1'b0;
          #1 chk_outs("async_rst", 2'd0, 16'd0, 1'b0, 1'b0, 16'd0);
          tick();
          start = 1'b0; pwm_cnt = t;
          #1 rst_n = 1'b1;
          #1 chk_outs("rst_idle", 2'd0, 16'd0, 1'b0, 1'b0, 16'd0);
          tick();
          #1 chk_outs("rst_idle2", 2'd0, 16'd0, 1'b0, 1'b0, 16'd0);
          return;
        end
      end else begin
        #1 chk_outs("run_nop", 2'd0, 16'd0, 1'b1, 1'b0, 16'(last));
      end
    end
    chk("budget_expired", 32'd1, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    top_cfg = '0; step = '0; hold = '0; pwm_cnt = '0;
    #3 chk_outs("reset", 2'd0, 16'd0, 1'b0, 1'b0, 16'd0);
    tick(); tick();
    rst_n = 1'b1;

    // stop in IDLE is ignored
    tick();
    stop = 1'b1;
    #1 chk_outs("idle_stop", 2'd0, 16'd0, 1'b0, 1'b0, 16'd0);
    tick();
    #1 chk_outs("idle_stop2", 2'd0, 16'd0, 1'b0, 1'b0, 16'd0);
    stop = 1'b0;

    run_ramp(16'd9, 16'd5, 8'd1, 0, 0);
    run_ramp(16'hFFFF, 16'h8000, 8'd1, 0, 0);
    run_ramp(16'd3, 16'd0, 8'd0, 0, 0);
    run_ramp(16'd20, 16'd3, 8'd2, 1, 2);
    run_ramp(16'd10, 16'd4, 8'd1, 2, 4);
    run_ramp(16'd0, 16'd7, 8'd3, 0, 0);

    for (int i = 0; i < 8; i++) begin
      run_ramp(16'($urandom_range(0, 40)), 16'($urandom_range(0, 12)),
               8'($urandom_range(0, 3)), (i % 3 == 2) ? 1 : 0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
